fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: reset vector, widths, FSM encoding, queue entry.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

  // One instruction-queue slot: fetched word tagged with its address.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Clear the byte offset of a target address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue: circular storage with pointers, count and flush.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = ENTRY_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Pointer/count update; flush wins over push and pop, simultaneous push+pop keeps count.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && !flush && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests, response queue, redirect flush.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = mips_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        instr_ready
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic [CNT_W-1:0] occupancy;

  logic         fifo_full, fifo_empty, fifo_push, fifo_flush, fifo_pop;
  fetch_entry_t push_entry, head_entry;
  logic         req_valid_c, req_fire, rsp_fire, head_vis;

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  // Request only in RUN while in-flight plus queued entries leave a free slot.
  always_comb begin
    req_valid_c = (state_q == ST_RUN) &&
                  ((SUM_W'(outstanding_q) + SUM_W'(occupancy)) < SUM_W'(QUEUE_DEPTH));
    req_fire    = req_valid_c && imem_req_ready;
    rsp_fire    = imem_rsp_valid && (outstanding_q != '0);
    fifo_pop    = !fifo_empty && instr_ready;
    head_vis    = rst && !fifo_empty;
  end

  // Next-state logic: PC advance, credit tracking, redirect flush and drop draining.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_count_d  = drop_count_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    push_entry    = '{pc: rsp_pc_q, instr: imem_rsp_data};
    case (state_q)
      ST_RUN: begin
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (redirect_valid) begin
          fifo_flush   = 1'b1;
          fetch_pc_d   = word_align(redirect_pc);
          rsp_pc_d     = word_align(redirect_pc);
          drop_count_d = outstanding_d;
          state_d      = (outstanding_d == '0) ? ST_RUN : ST_FLUSH;
        end else if (rsp_fire && !fifo_full) begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + 32'd4;
        end
      end
      ST_FLUSH: begin
        if (rsp_fire) drop_count_d = drop_count_q - CNT_W'(1);
        if (redirect_valid) begin
          fetch_pc_d = word_align(redirect_pc);
          rsp_pc_d   = word_align(redirect_pc);
        end
        if (drop_count_d == '0) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous active-low reset abandoning in-flight work.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Outputs come straight from registered state, forced to zero while in reset.
  always_comb begin
    imem_req_valid = rst && req_valid_c;
    imem_req_addr  = rst ? fetch_pc_q : '0;
    instr_valid    = head_vis;
    instr          = head_vis ? head_entry.instr : '0;
    instr_pc       = head_vis ? head_entry.pc : '0;
    instr_pc4      = head_vis ? (head_entry.pc + 32'd4) : '0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an epoch-based fetch model.
module tb_fetch_unit;

  localparam int unsigned QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, instr_pc, instr_pc4;

  fetch_unit #(.QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc4      (instr_pc4),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  infl_t       pipe[$];
  exp_t        expq[$];
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  int          epoch = 0, cyc = 0, lat = 1;
  int          checks = 0, failures = 0, drops = 0, coincide = 0, first_iv_cyc = -1;
  logic [31:0] model_pc = RPC;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: compare outputs against the model, then apply the upcoming edge's effects.
  always @(negedge clk) begin
    int    old_n;
    logic  exp_rv, pop;
    infl_t f;
    if (!rst) begin
      check("rst_req_valid", 32'(imem_req_valid), 0);
      check("rst_instr_valid", 32'(instr_valid), 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      check("rst_instr_pc4", instr_pc4, 0);
      pipe.delete();
      expq.delete();
      model_pc = RPC;
    end else begin
      old_n = 0;
      foreach (pipe[i]) if (pipe[i].epoch != epoch) old_n++;
      exp_rv = (old_n == 0) && ((pipe.size() + expq.size()) < QD);
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (imem_req_valid && exp_rv) check("req_addr", imem_req_addr, model_pc);
      check("instr_valid", 32'(instr_valid), 32'(expq.size() != 0));
      if (instr_valid && expq.size() != 0) begin
        check("instr", instr, expq[0].data);
        check("instr_pc", instr_pc, expq[0].pc);
        check("instr_pc4", instr_pc4, expq[0].pc + 32'd4);
      end
      if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
      pop = instr_valid && instr_ready;
      if (pop && expq.size() != 0) void'(expq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pipe.push_back('{model_pc, epoch, cyc + lat});
        acc_log.push_back(imem_req_addr);
        acc_cyc.push_back(cyc);
        model_pc = model_pc + 32'd4;
      end
      if (imem_rsp_valid && pipe.size() != 0) begin
        f = pipe.pop_front();
        if (f.epoch == epoch && !redirect_valid) expq.push_back('{f.addr, mem_data(f.addr)});
        else drops++;
      end
      if (redirect_valid) begin
        if (pop && imem_rsp_valid) coincide++;
        expq.delete();
        epoch++;
        model_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // One clock of stimulus; the memory model answers the oldest request once due.
  task automatic drive(input logic r, input logic rdy, input logic rd,
                       input logic [31:0] tgt, input logic irdy);
    @(posedge clk);
    cyc++;
    #1;
    rst            = r;
    imem_req_ready = rdy;
    redirect_valid = rd;
    redirect_pc    = tgt;
    instr_ready    = irdy;
    if (pipe.size() != 0 && pipe[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(pipe[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n0, rc;
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // Startup stream, latency 1, always consuming.
    lat = 1;
    do_reset(3);
    acc_log.delete(); acc_cyc.delete(); first_iv_cyc = -1;
    repeat (12) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("A_nreq", 32'(acc_log.size() >= 4), 1);
    if (acc_log.size() >= 4) begin
      check("A_addr0", acc_log[0], 32'h0);
      check("A_addr1", acc_log[1], 32'h4);
      check("A_addr2", acc_log[2], 32'h8);
      check("A_addr3", acc_log[3], 32'hC);
      check("A_iv_latency", 32'(first_iv_cyc - acc_cyc[0]), 32'(lat + 1));
    end

    // Consumer stalled: credit allows exactly QD requests.
    do_reset(2);
    acc_log.delete(); acc_cyc.delete();
    repeat (12) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk); #1;
    check("B_nreq", 32'(acc_log.size()), QD);
    check("B_req_valid", 32'(imem_req_valid), 0);
    check("B_head_valid", 32'(instr_valid), 1);
    check("B_head_pc", instr_pc, RPC);

    // Redirect with two requests in flight at latency 3.
    lat = 3;
    do_reset(2);
    acc_log.delete(); acc_cyc.delete(); drops = 0;
    repeat (2) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
    rc = cyc;
    n0 = acc_log.size();
    repeat (10) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("C_drops", 32'(drops), 2);
    check("C_has_req", 32'(acc_log.size() > n0), 1);
    if (acc_log.size() > n0) begin
      check("C_next_addr", acc_log[n0], 32'h0000_0100);
      check("C_flush_len", 32'(acc_cyc[n0] - rc), 3);
    end

    // Redirect near the top of the address space wraps to zero.
    lat = 1;
    do_reset(2);
    acc_log.delete(); acc_cyc.delete();
    repeat (4) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    n0 = acc_log.size();
    repeat (10) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("D_nreq", 32'(acc_log.size() >= n0 + 3), 1);
    if (acc_log.size() >= n0 + 3) begin
      check("D_addr0", acc_log[n0], 32'hFFFF_FFF8);
      check("D_addr1", acc_log[n0 + 1], 32'hFFFF_FFFC);
      check("D_addr2", acc_log[n0 + 2], 32'h0000_0000);
    end

    // Redirect coinciding with a pop and a response.
    do_reset(2);
    coincide = 0;
    repeat (6) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk); #1;
    check("E_coincide", 32'(coincide), 1);
    check("E_iv_after", 32'(instr_valid), 0);

    // One-cycle reset in the middle of a burst.
    lat = 2;
    do_reset(2);
    repeat (6) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk); #1;
    check("F_req_valid", 32'(imem_req_valid), 0);
    check("F_instr_valid", 32'(instr_valid), 0);
    check("F_instr", instr, 0);
    check("F_instr_pc", instr_pc, 0);
    check("F_instr_pc4", instr_pc4, 0);
    n0 = acc_log.size();
    repeat (6) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("F_has_req", 32'(acc_log.size() > n0), 1);
    if (acc_log.size() > n0) check("F_first_addr", acc_log[n0], RPC);

    // Random traffic: ready, consumption, redirects, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        lat = int'($urandom_range(1, 4));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      end else begin
        drive(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
              $urandom, ($urandom_range(0, 3) != 0));
      end
    end
    repeat (4) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
